// File: rtl/dmem_responder.sv
// dmem_responder: single-port data-memory slave with a valid/ready request channel and a
// valid/ready response channel. One transaction in flight; response latency WAIT_CYCLES+1.
//
// Parameters:
//   XLEN        data/address width (lane decode assumes 32-bit words)
//   DEPTH_WORDS number of XLEN-bit words, power of two
//   WAIT_CYCLES extra response latency, 0..15
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake (ready only while idle)
//   req_we, req_size            store/load, size (000 byte, 001 half, 010 word)
//   req_unsigned                zero-extend loads when set
//   req_addr, req_wdata         byte address, right-aligned store data
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata, rsp_err          extended load data (0 for stores/errors), access fault
// Build option:
//   DMEM_MISALIGN_CHECK_EN  defined: misaligned half/word accesses fault.
//                           undefined: misaligned low address bits are cleared.
module dmem_responder #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int unsigned     AW         = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] ADDR_LIMIT = XLEN'(4 * DEPTH_WORDS);
  localparam logic [3:0]      WAIT_LAST  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [2:0]      SizeByte   = 3'b000;
  localparam logic [2:0]      SizeHalf   = 3'b001;
  localparam logic [2:0]      SizeWord   = 3'b010;

  typedef enum logic [1:0] {StIdle = 2'd0, StWait = 2'd1, StResp = 2'd2} state_e;

  state_e          r_state;
  logic [3:0]      r_cnt;
  logic            r_we;
  logic [2:0]      r_size;
  logic            r_unsigned;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic            r_rsp_valid;
  logic [XLEN-1:0] r_rsp_rdata;
  logic            r_rsp_err;
  logic [XLEN-1:0] r_mem [DEPTH_WORDS];

  // With WAIT_CYCLES=0 the access happens on the accept edge itself, so the datapath
  // works on the live request while idle and on the captured copy otherwise.
  logic            w_sel_live;
  logic            w_we;
  logic [2:0]      w_size;
  logic            w_uns;
  logic [XLEN-1:0] w_addr;
  logic [XLEN-1:0] w_wdata;
  logic            w_size_ok;
  logic            w_oob;
  logic            w_err;
  logic [1:0]      w_lane;
  logic [AW-1:0]   w_idx;
  logic [XLEN-1:0] w_old;
  logic [XLEN-1:0] w_new;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load;
  logic [XLEN-1:0] w_rdata;
  logic            w_enter_resp;

  assign w_sel_live = (r_state == StIdle);
  assign w_we       = w_sel_live ? req_we       : r_we;
  assign w_size     = w_sel_live ? req_size     : r_size;
  assign w_uns      = w_sel_live ? req_unsigned : r_unsigned;
  assign w_addr     = w_sel_live ? req_addr     : r_addr;
  assign w_wdata    = w_sel_live ? req_wdata    : r_wdata;

  assign w_size_ok = (w_size == SizeByte) || (w_size == SizeHalf) || (w_size == SizeWord);
  assign w_oob     = (w_addr >= ADDR_LIMIT);
  assign w_idx     = w_addr[AW+1:2];

`ifdef DMEM_MISALIGN_CHECK_EN
  logic w_misalign;
  assign w_misalign = ((w_size == SizeHalf) && w_addr[0]) ||
                      ((w_size == SizeWord) && (w_addr[1:0] != 2'b00));
  assign w_err      = !w_size_ok || w_oob || w_misalign;
  assign w_lane     = w_addr[1:0];
`else
  assign w_err = !w_size_ok || w_oob;
  always_comb begin
    w_lane = w_addr[1:0];
    if (w_size == SizeHalf) w_lane[0] = 1'b0;
    if (w_size == SizeWord) w_lane    = 2'b00;
  end
`endif

  assign w_old  = r_mem[w_idx];
  assign w_byte = w_old[{w_lane, 3'b000} +: 8];
  assign w_half = w_old[{w_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_new = w_old;
    w_load = w_old;
    case (w_size)
      SizeByte: begin
        w_new[{w_lane, 3'b000} +: 8] = w_wdata[7:0];
        w_load = w_uns ? {{(XLEN-8){1'b0}}, w_byte} : {{(XLEN-8){w_byte[7]}}, w_byte};
      end
      SizeHalf: begin
        w_new[{w_lane[1], 4'b0000} +: 16] = w_wdata[15:0];
        w_load = w_uns ? {{(XLEN-16){1'b0}}, w_half} : {{(XLEN-16){w_half[15]}}, w_half};
      end
      default: begin
        w_new  = w_wdata;
        w_load = w_old;
      end
    endcase
  end

  assign w_rdata = (w_err || w_we) ? '0 : w_load;

  assign w_enter_resp = ((r_state == StIdle) && req_valid && (WAIT_CYCLES == 0)) ||
                        ((r_state == StWait) && (r_cnt == WAIT_LAST));

  // Storage is deliberately not reset; a pending store is lost if reset hits before RESP.
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_we && !w_err) r_mem[w_idx] <= w_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_size      <= 3'b000;
      r_unsigned  <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_cnt      <= 4'd0;
            if (WAIT_CYCLES == 0) begin
              r_state     <= StResp;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_rdata;
              r_rsp_err   <= w_err;
            end else begin
              r_state <= StWait;
            end
          end
        end
        StWait: begin
          if (r_cnt == WAIT_LAST) begin
            r_state     <= StResp;
            r_cnt       <= 4'd0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rdata;
            r_rsp_err   <= w_err;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            r_state     <= StIdle;
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_ready = (r_state == StIdle);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a driver issues requests and pushes the expected
// response from a byte-array reference model; a monitor pops and compares on each
// response handshake and also checks latency, stall stability and the return to idle.
module tb_dmem_responder;

  localparam int unsigned W     = 1;
  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(
    .XLEN        (32),
    .DEPTH_WORDS (DEPTH),
    .WAIT_CYCLES (W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         hold = 0;
  logic [7:0] mem_m [4*DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: byte-addressed memory, naturally aligned accesses of 1<<size bytes.
  task automatic model(input logic we, input logic [2:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
    int n;
    int base;
    logic [31:0] v;
    rd = 32'h0;
    er = 1'b0;
    if (sz > 3'd2 || a >= 32'(4 * DEPTH)) begin
      er = 1'b1;
      return;
    end
    n = 1 << sz;
`ifdef DMEM_MISALIGN_CHECK_EN
    if ((int'(a) % n) != 0) begin
      er = 1'b1;
      return;
    end
`endif
    base = int'(a) - (int'(a) % n);
    if (we) begin
      for (int k = 0; k < n; k++) mem_m[base + k] = wd[8*k +: 8];
    end else begin
      v = 32'h0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = mem_m[base + k];
      if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      rd = v;
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input bit use_exp,
                       input logic [31:0] xr, input logic xe, input bit abort);
    exp_t e;
    logic [31:0] mr;
    logic me;
    int t;
    @(negedge clk);
    req_we = we;
    req_size = sz;
    req_unsigned = uns;
    req_addr = a;
    req_wdata = wd;
    req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout: got 0 expected 1 (t=%0t)", $time);
      req_valid = 1'b0;
      return;
    end
    if (!abort) begin
      model(we, sz, uns, a, wd, mr, me);
      e.rdata = use_exp ? xr : mr;
      e.err   = use_exp ? xe : me;
      e.acc   = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (abort) rst_n = 1'b0;
  endtask

  // Response-side ready: random back-pressure, or forced low while hold > 0.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold > 0) begin
        rsp_ready = 1'b0;
        hold--;
      end else begin
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor
  initial begin
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic        hs = 1'b0;
    logic [31:0] prd = 32'h0;
    logic        perr = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
        pr = 1'b0;
        hs = 1'b0;
      end else begin
        if (hs) begin
          check("idle_after_rsp_valid", {31'b0, rsp_valid}, 32'd0);
          check("idle_after_rsp_ready", {31'b0, req_ready}, 32'd1);
        end
        hs = 1'b0;
        if (rsp_valid) begin
          check("req_ready_in_resp", {31'b0, req_ready}, 32'd0);
          if (!pv) begin
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (t=%0t)",
                       $time);
            end else begin
              check("latency", 32'(cyc), 32'(q[0].acc + int'(W) + 1));
            end
          end else if (!pr) begin
            check("stall_rdata", rsp_rdata, prd);
            check("stall_err", {31'b0, rsp_err}, {31'b0, perr});
          end
          if (rsp_ready) begin
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_handshake: got response expected none (t=%0t)", $time);
            end else begin
              e = q.pop_front();
              check("rdata", rsp_rdata, e.rdata);
              check("err", {31'b0, rsp_err}, {31'b0, e.err});
            end
            hs = 1'b1;
          end
        end
        pv = rsp_valid;
        pr = rsp_ready;
        prd = rsp_rdata;
        perr = rsp_err;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  sz;
    logic [31:0] a;
    int          t;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 3'b000;
    req_unsigned = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_req_ready", {31'b0, req_ready}, 32'd1);
    rst_n = 1'b1;

    // Fill every word so later loads read defined contents.
    for (int i = 0; i < int'(DEPTH); i++)
      issue(1'b1, 3'b010, 1'b0, 32'(4 * i), $urandom, 1'b0, 32'h0, 1'b0, 1'b0);

    issue(1'b1, 3'b010, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 3'b010, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    issue(1'b1, 3'b000, 1'b0, 32'h13, 32'h80, 1'b1, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 3'b000, 1'b0, 32'h13, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0, 1'b0);
    issue(1'b0, 3'b000, 1'b1, 32'h13, 32'h0, 1'b1, 32'h00000080, 1'b0, 1'b0);
    issue(1'b0, 3'b010, 1'b0, 32'h10, 32'h0, 1'b1, 32'h80ADBEEF, 1'b0, 1'b0);
`ifdef DMEM_MISALIGN_CHECK_EN
    issue(1'b0, 3'b001, 1'b0, 32'h11, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
`else
    issue(1'b0, 3'b001, 1'b0, 32'h11, 32'h0, 1'b1, 32'hFFFFBEEF, 1'b0, 1'b0);
`endif
    issue(1'b1, 3'b010, 1'b0, 32'h400, 32'hCAFEF00D, 1'b1, 32'h0, 1'b1, 1'b0);
    issue(1'b0, 3'b010, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 3'b011, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);

    hold = 8;
    issue(1'b0, 3'b010, 1'b0, 32'h10, 32'h0, 1'b1, 32'h80ADBEEF, 1'b0, 1'b0);

    // Reset while the store sits in WAIT: the store must be dropped.
    issue(1'b1, 3'b010, 1'b0, 32'h20, 32'h12345678, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    check("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    check("midrst_rsp_valid2", {31'b0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    issue(1'b0, 3'b010, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH - 1));
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
            1'b0, 32'h0, 1'b0, 1'b0);
      if ($urandom_range(0, 3) == 0)
        issue(1'b0, 3'b010, 1'b0, a, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    end

    t = 0;
    while ((q.size() != 0 || rsp_valid) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", 32'(q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter XLEN, default 32: data and address width.
REQ-002 SHALL have parameter DEPTH_WORDS, default 256: number of XLEN-bit storage words (power of two).
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, range 0..15: added response latency.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  initiator presents a request.
REQ-007 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-008 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_size  input  3  access size in the package dmem-size encoding: BYTE=000, HALF=001, WORD=010.
REQ-010 SHALL have port req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0; ignored for stores.
REQ-011 SHALL have port req_addr  input  XLEN  byte address.
REQ-012 SHALL have port req_wdata  input  XLEN  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-013 SHALL have port rsp_valid  output  1  response available.
REQ-014 SHALL have port rsp_ready  input  1  initiator consumes the response.
REQ-015 SHALL have port rsp_rdata  output  XLEN  load result, extended to XLEN; 0 for stores and errors.
REQ-016 SHALL have port rsp_err  output  1  access fault for this response.

Function
REQ-017 SHALL implement the FSM states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 In IDLE, req_valid=1 SHALL capture we/size/unsigned/addr/wdata at that edge; the next state SHALL be WAIT if WAIT_CYCLES>0, otherwise RESP.
REQ-019 WAIT SHALL count WAIT_CYCLES cycles and then enter RESP; rsp_valid SHALL rise exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-020 The memory access (the read, or the store commit) SHALL occur on the edge entering RESP; rsp_rdata/rsp_err SHALL be registered and stable while rsp_valid=1.
REQ-021 RESP SHALL hold rsp_valid=1 until rsp_ready=1, then return to IDLE; no request SHALL be accepted in the same cycle (one transaction per WAIT_CYCLES+2 cycles minimum).
REQ-022 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; byte lane = addr[1:0]; half lane = addr[1].
REQ-023 Stores SHALL write only the addressed lanes (byte: 1 lane, half: 2 lanes, word: 4 lanes); other bytes are unchanged.
REQ-024 Loads SHALL extract the addressed lanes and extend them per req_unsigned; word loads SHALL be returned unmodified.
REQ-025 The following SHALL set rsp_err=1, force rsp_rdata=0 and suppress any write: addr >= 4*DEPTH_WORDS; req_size not in {000,001,010}.
REQ-026 A store of the same word immediately followed by a load of it SHALL return the newly stored data.

Reset
REQ-027 With rst_n=0 the FSM SHALL be in IDLE, with rsp_valid=0, rsp_err=0, rsp_rdata=0, the wait counter at 0, and req_ready=1 once rst_n=1.
REQ-028 Reset asserted mid-transaction SHALL drop it; a store not yet committed (still in WAIT) SHALL NOT write; memory contents are not reset.

Configuration
REQ-029 Macro DMEM_MISALIGN_CHECK_EN defined: a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL give rsp_err=1 and no write.
REQ-030 Macro not defined: misaligned addresses SHALL have their low bits cleared (half: addr[0]=0; word: addr[1:0]=0), the access SHALL be performed and rsp_err SHALL be 0.

Verification
REQ-031 Reset, then SW 0xDEADBEEF @0x10 followed by LW @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after each accept (WAIT_CYCLES=1).
REQ-032 SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
REQ-033 LH @0x11: with the macro -> rsp_err=1, rdata=0; without the macro -> rdata=0xFFFFBEEF (sign-extended half at 0x10).
REQ-034 SW @0x400 (DEPTH_WORDS=256) -> rsp_err=1, and memory is unchanged; req_size=011 -> rsp_err=1.
REQ-035 Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stay stable and req_ready=0 throughout; release -> IDLE on the next cycle.
REQ-036 Assert rst_n=0 during WAIT of SW 0x12345678 @0x20 -> rsp_valid=0; a later LW @0x20 returns the prior contents.
